// File: rtl/servant_wb_sched.sv
// Registered Wishbone scheduler sharing one slave bus between debug, ibus, dbus.
// Holds one grant per bus cycle, with debug/CPU fairness and ack timeout.
module servant_wb_sched #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_dbg_adr,
    input  logic [31:0] i_wb_dbg_dat,
    input  logic [3:0]  i_wb_dbg_sel,
    input  logic        i_wb_dbg_we,
    input  logic        i_wb_dbg_cyc,
    output logic [31:0] o_wb_dbg_rdt,
    output logic        o_wb_dbg_ack,
    input  logic [31:0] i_wb_ibus_adr,
    input  logic        i_wb_ibus_cyc,
    output logic [31:0] o_wb_ibus_rdt,
    output logic        o_wb_ibus_ack,
    input  logic [31:0] i_wb_dbus_adr,
    input  logic [31:0] i_wb_dbus_dat,
    input  logic [3:0]  i_wb_dbus_sel,
    input  logic        i_wb_dbus_we,
    input  logic        i_wb_dbus_cyc,
    output logic [31:0] o_wb_dbus_rdt,
    output logic        o_wb_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        G_DBG,
        G_IBUS,
        G_DBUS
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_dbg;
    logic          last_dbg_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          gnt_cyc;
    logic          tmo;
    logic          done;
    logic          term;

    always_comb begin
        gnt_cyc = 1'b0;
        unique case (state)
            G_DBG:   gnt_cyc = i_wb_dbg_cyc;
            G_IBUS:  gnt_cyc = i_wb_ibus_cyc;
            G_DBUS:  gnt_cyc = i_wb_dbus_cyc;
            default: gnt_cyc = 1'b0;
        endcase
        tmo  = (TIMEOUT != 0) && (state != IDLE) && gnt_cyc &&
               !i_wb_ack && (cnt == CNT_MAX);
        done = (state != IDLE) && (i_wb_ack || tmo);
        // a master dropping cyc aborts without touching fairness
        term = done || ((state != IDLE) && !gnt_cyc);
    end

    always_comb begin
        state_nxt    = state;
        last_dbg_nxt = last_dbg;
        cnt_nxt      = cnt;
        if (state == IDLE) begin
            cnt_nxt = '0;
            if (last_dbg && (i_wb_ibus_cyc || i_wb_dbus_cyc))
                state_nxt = i_wb_ibus_cyc ? G_IBUS : G_DBUS;
            else if (i_wb_dbg_cyc)
                state_nxt = G_DBG;
            else if (i_wb_ibus_cyc)
                state_nxt = G_IBUS;
            else if (i_wb_dbus_cyc)
                state_nxt = G_DBUS;
        end else if (term) begin
            state_nxt = IDLE;
            if (done)
                last_dbg_nxt = (state == G_DBG);
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            last_dbg <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            last_dbg <= last_dbg_nxt;
            cnt      <= cnt_nxt;
        end
    end

    always_comb begin
        o_wb_adr = '0;
        o_wb_dat = '0;
        o_wb_sel = '0;
        o_wb_we  = 1'b0;
        unique case (state)
            G_DBG: begin
                o_wb_adr = i_wb_dbg_adr;
                o_wb_dat = i_wb_dbg_dat;
                o_wb_sel = i_wb_dbg_sel;
                o_wb_we  = i_wb_dbg_we;
            end
            G_IBUS: begin
                o_wb_adr = i_wb_ibus_adr;
                o_wb_sel = 4'hf;
            end
            G_DBUS: begin
                o_wb_adr = i_wb_dbus_adr;
                o_wb_dat = i_wb_dbus_dat;
                o_wb_sel = i_wb_dbus_sel;
                o_wb_we  = i_wb_dbus_we;
            end
            default: ;
        endcase
        o_wb_cyc  = gnt_cyc && !tmo;
        o_timeout = tmo;

        o_wb_dbg_ack  = (state == G_DBG) && (i_wb_ack || tmo);
        o_wb_ibus_ack = (state == G_IBUS) && (i_wb_ack || tmo);
        o_wb_dbus_ack = (state == G_DBUS) && (i_wb_ack || tmo);

        o_wb_dbg_rdt  = (tmo && state == G_DBG) ? '0 : i_wb_rdt;
        o_wb_ibus_rdt = (tmo && state == G_IBUS) ? '0 : i_wb_rdt;
        o_wb_dbus_rdt = (tmo && state == G_DBUS) ? '0 : i_wb_rdt;
    end

endmodule

// File: tb/tb_servant_wb_sched.sv
// Randomized bench for servant_wb_sched against a transaction-level model.
// Directed scenarios cover fetch, timeout, abort and reset mid-grant.
module tb_servant_wb_sched;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dbg_adr = '0, dbg_dat = '0;
    logic [3:0]  dbg_sel = '0;
    logic        dbg_we = 1'b0, dbg_cyc = 1'b0;
    logic [31:0] dbg_rdt;
    logic        dbg_ack;
    logic [31:0] ibus_adr = '0;
    logic        ibus_cyc = 1'b0;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] dbus_adr = '0, dbus_dat = '0;
    logic [3:0]  dbus_sel = '0;
    logic        dbus_we = 1'b0, dbus_cyc = 1'b0;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [31:0] wb_adr, wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc;
    logic [31:0] wb_rdt = '0;
    logic        wb_ack = 1'b0;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: who owns the bus, how long it waited, fairness
    int   m_owner = 0;
    int   m_wait  = 0;
    bit   m_last_dbg = 1'b0;
    logic [2:0] prev_ack = '0;

    always #5 clk = ~clk;

    servant_wb_sched #(.TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_dbg_adr(dbg_adr), .i_wb_dbg_dat(dbg_dat),
        .i_wb_dbg_sel(dbg_sel), .i_wb_dbg_we(dbg_we),
        .i_wb_dbg_cyc(dbg_cyc), .o_wb_dbg_rdt(dbg_rdt),
        .o_wb_dbg_ack(dbg_ack),
        .i_wb_ibus_adr(ibus_adr), .i_wb_ibus_cyc(ibus_cyc),
        .o_wb_ibus_rdt(ibus_rdt), .o_wb_ibus_ack(ibus_ack),
        .i_wb_dbus_adr(dbus_adr), .i_wb_dbus_dat(dbus_dat),
        .i_wb_dbus_sel(dbus_sel), .i_wb_dbus_we(dbus_we),
        .i_wb_dbus_cyc(dbus_cyc), .o_wb_dbus_rdt(dbus_rdt),
        .o_wb_dbus_ack(dbus_ack),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel),
        .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
        .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
        .o_timeout(timeout)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_owner();
        if (m_last_dbg && (ibus_cyc || dbus_cyc))
            return ibus_cyc ? 2 : 3;
        if (dbg_cyc)  return 1;
        if (ibus_cyc) return 2;
        if (dbus_cyc) return 3;
        return 0;
    endfunction

    // compare one cycle of outputs with the model, then advance the model
    task automatic tick();
        logic        oc, fire;
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        logic        e_we;
        logic [2:0]  e_ack;
        logic [31:0] e_rdt [3];
        #1;
        oc = (m_owner == 1) ? dbg_cyc : (m_owner == 2) ? ibus_cyc :
             (m_owner == 3) ? dbus_cyc : 1'b0;
        fire = (m_owner != 0) && oc && !wb_ack && (m_wait == TMO - 1);
        e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0;
        if (m_owner == 1) begin
            e_adr = dbg_adr; e_dat = dbg_dat; e_sel = dbg_sel; e_we = dbg_we;
        end else if (m_owner == 2) begin
            e_adr = ibus_adr; e_sel = 4'hf;
        end else if (m_owner == 3) begin
            e_adr = dbus_adr; e_dat = dbus_dat; e_sel = dbus_sel; e_we = dbus_we;
        end
        for (int k = 0; k < 3; k++) begin
            e_ack[2-k] = (m_owner == k + 1) && (wb_ack || fire);
            e_rdt[k]   = (fire && m_owner == k + 1) ? 32'h0 : wb_rdt;
        end
        check("cyc", {31'b0, wb_cyc}, {31'b0, oc && !fire});
        check("adr", wb_adr, e_adr);
        check("dat", wb_dat, e_dat);
        check("sel", {28'b0, wb_sel}, {28'b0, e_sel});
        check("we", {31'b0, wb_we}, {31'b0, e_we});
        check("acks", {29'b0, dbg_ack, ibus_ack, dbus_ack}, {29'b0, e_ack});
        check("timeout", {31'b0, timeout}, {31'b0, fire});
        check("dbg_rdt", dbg_rdt, e_rdt[0]);
        check("ibus_rdt", ibus_rdt, e_rdt[1]);
        check("dbus_rdt", dbus_rdt, e_rdt[2]);
        prev_ack = e_ack;
        @(posedge clk);
        if (rst) begin
            m_owner = 0; m_wait = 0; m_last_dbg = 1'b0;
        end else if (m_owner == 0) begin
            m_owner = pick_owner(); m_wait = 0;
        end else if (wb_ack || fire || !oc) begin
            if (wb_ack || fire) m_last_dbg = (m_owner == 1);
            m_owner = 0;
        end else begin
            m_wait++;
        end
        @(negedge clk);
    endtask

    task automatic quiesce();
        dbg_cyc = 0; ibus_cyc = 0; dbus_cyc = 0; wb_ack = 0; rst = 0;
        tick();
        tick();
    endtask

    initial begin
        int t;
        bit seen;
        int ackp;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_cyc", {31'b0, wb_cyc}, 32'h0);
        check("rst_acks", {29'b0, dbg_ack, ibus_ack, dbus_ack}, 32'h0);
        check("rst_tmo", {31'b0, timeout}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // single instruction fetch acked on cycle 3
        ibus_adr = 32'h0000_0100;
        for (int i = 0; i < 5; i++) begin
            ibus_cyc = (i < 4);
            wb_ack = (i == 3);
            wb_rdt = (i == 3) ? 32'h0000_0013 : 32'hffff_ffff;
            #1;
            check("fetch_cyc", {31'b0, wb_cyc}, {31'b0, i >= 1 && i <= 3});
            check("fetch_ack", {31'b0, ibus_ack}, {31'b0, i == 3});
            if (i == 3) check("fetch_rdt", ibus_rdt, 32'h13);
            tick();
        end
        quiesce();

        // unacked dbus write must time out on grant cycle TMO
        dbus_cyc = 1; dbus_we = 1; dbus_adr = 32'hdead_0000;
        dbus_sel = 4'hf; wb_rdt = 32'hdead_beef;
        seen = 0; t = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (timeout) begin
                seen = 1; t = i;
                check("tmo_ack", {31'b0, dbus_ack}, 32'h1);
                check("tmo_rdt", dbus_rdt, 32'h0);
                check("tmo_cyc", {31'b0, wb_cyc}, 32'h0);
            end
            tick();
        end
        check("tmo_cycle", t, TMO);
        quiesce();

        // debug aborts on cycle 2, pending ibus granted 2 cycles later
        dbg_cyc = 1; ibus_cyc = 1; dbg_adr = 32'h1000_0000;
        ibus_adr = 32'h0000_0200;
        tick();
        tick();
        dbg_cyc = 0;
        #1;
        check("abort_cyc", {31'b0, wb_cyc}, 32'h0);
        check("abort_ack", {31'b0, dbg_ack}, 32'h0);
        tick();
        tick();
        #1;
        check("abort_next", {31'b0, wb_cyc}, 32'h1);
        check("abort_adr", wb_adr, 32'h0000_0200);
        wb_ack = 1;
        tick();
        quiesce();

        // reset during a dbus grant drops the transfer
        dbus_cyc = 1; dbus_adr = 32'h2000_0000;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("rstmid_cyc", {31'b0, wb_cyc}, 32'h0);
        check("rstmid_ack", {31'b0, dbus_ack}, 32'h0);
        tick();
        #1;
        check("rstmid_regrant", {31'b0, wb_cyc}, 32'h1);
        wb_ack = 1;
        tick();
        quiesce();

        // randomized traffic, second phase with a lazy slave
        for (int i = 0; i < 1600; i++) begin
            ackp = (i < 1000) ? 35 : 6;
            if (dbg_cyc && !prev_ack[2]) begin
                if ($urandom_range(99) < 3) dbg_cyc = 0;
            end else dbg_cyc = 1'($urandom_range(1));
            if (ibus_cyc && !prev_ack[1]) begin
                if ($urandom_range(99) < 3) ibus_cyc = 0;
            end else ibus_cyc = 1'($urandom_range(1));
            if (dbus_cyc && !prev_ack[0]) begin
                if ($urandom_range(99) < 3) dbus_cyc = 0;
            end else dbus_cyc = 1'($urandom_range(1));
            dbg_adr = $urandom; dbg_dat = $urandom;
            dbg_sel = 4'($urandom); dbg_we = 1'($urandom);
            ibus_adr = $urandom;
            dbus_adr = $urandom; dbus_dat = $urandom;
            dbus_sel = 4'($urandom); dbus_we = 1'($urandom);
            wb_rdt = $urandom;
            wb_ack = ($urandom_range(99) < ackp);
            rst = ($urandom_range(299) == 0);
            tick();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
